// File: rtl/simon_pkg.sv
// Shared types and constants for the colour-button front-end.
//   colour_t      : 2-bit colour code carried with each accepted press
//   btn_state_t   : encoding of the button conditioner FSM
//   DEFAULT_*     : default debounce / timeout lengths in clock cycles
//   is_onehot     : true when exactly one button bit is set
//   btn_to_colour : index of the set bit of a one-hot button pattern
package simon_pkg;

  localparam int unsigned BTN_W            = 4;
  localparam int unsigned DEFAULT_DEBOUNCE = 16;
  localparam int unsigned DEFAULT_TIMEOUT  = 1000000;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } colour_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DEB_REL   = 3'd1,
    S_READY     = 3'd2,
    S_DEB_PRESS = 3'd3,
    S_HELD      = 3'd4,
    S_TIMED_OUT = 3'd5
  } btn_state_t;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  function automatic logic is_onehot(input logic [BTN_W-1:0] p);
    return (p != '0) && ((p & (p - BTN_W'(1))) == '0);
  endfunction

  // Bit n maps to colour n; only meaningful for one-hot patterns.
  function automatic colour_t btn_to_colour(input logic [BTN_W-1:0] p);
    colour_t c;
    c = RED;
    for (int i = 0; i < BTN_W; i++) begin
      if (p[i]) c = colour_t'(2'(i));
    end
    return c;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button front-end bus: arm/raw button levels in, press events and status out.
//   arm          : WAIT stage accepts input
//   btn_raw      : asynchronous button levels, bit n = colour n
//   press_valid  : 1-cycle pulse, single-button press accepted
//   press_colour : colour of the last accepted press
//   multi_press  : 1-cycle pulse, debounced press with several buttons
//   busy         : a press or release is being debounced or held
//   timeout      : 1-cycle pulse, idle-ready timeout (BTN_TIMEOUT_EN builds)
// master = consumer/driver side, slave = button_conditioner.
interface button_conditioner_if;
  import simon_pkg::*;

  logic             arm;
  logic [BTN_W-1:0] btn_raw;
  logic             press_valid;
  logic [1:0]       press_colour;
  logic             multi_press;
  logic             busy;
  logic             timeout;

  modport master (
    output arm, btn_raw,
    input  press_valid, press_colour, multi_press, busy, timeout
  );

  modport slave (
    input  arm, btn_raw,
    output press_valid, press_colour, multi_press, busy, timeout
  );

endinterface

// File: rtl/btn_sync.sv
// Two-flop synchroniser for asynchronous level inputs.
//   clk, reset : clock, synchronous active-high reset
//   d          : asynchronous input bus
//   q          : synchronised output, two cycles behind d
module btn_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Colour-button conditioner: synchronises and debounces the four buttons on
// press and release, emitting one press event per physical press.
//   clk, reset : clock, synchronous active-high reset
//   bus        : button_conditioner_if.slave (arm, btn_raw in; press_valid,
//                press_colour, multi_press, busy, timeout out)
// Optional feature macro: BTN_TIMEOUT_EN enables the idle-ready timeout and the
// S_TIMED_OUT state; without it timeout is tied low.
module button_conditioner
  import simon_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time parameter sanity.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("button_conditioner: TIMEOUT_CYCLES must be at least 1");
  end

  logic [BTN_W-1:0] sync_q;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BTN_W-1:0] pat_q, pat_d;
  logic             deb_done_c;

  logic    press_valid_q, press_valid_d;
  logic    multi_press_q, multi_press_d;
  logic    busy_q, busy_d;
  logic    timeout_q, timeout_d;
  colour_t colour_q, colour_d;

`ifdef BTN_TIMEOUT_EN
  localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              timeout_hit_c;
`endif

  btn_sync #(.WIDTH(BTN_W)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn_raw),
    .q     (sync_q)
  );

  // A press completes when the latched pattern survived the full debounce
  // window; arm low overrides completion.
  assign deb_done_c = bus.arm && (state_q == S_DEB_PRESS) &&
                      (sync_q == pat_q) && (cnt_q == CNT_LAST);

`ifdef BTN_TIMEOUT_EN
  // A press arriving on the terminal cycle wins over the timeout.
  assign timeout_hit_c = bus.arm && (state_q == S_READY) &&
                         (sync_q == '0) && (tcnt_q == TCNT_LAST);
`endif

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
`ifdef BTN_TIMEOUT_EN
      tcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
`ifdef BTN_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
`endif
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
`ifdef BTN_TIMEOUT_EN
    tcnt_d  = '0;
`endif
    if (!bus.arm) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_DEB_REL;
          cnt_d   = '0;
        end
        // Buttons must read all-released for the full window before READY.
        S_DEB_REL: begin
          if (sync_q != '0) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_READY: begin
          if (sync_q != '0) begin
            pat_d   = sync_q;
            cnt_d   = '0;
            state_d = S_DEB_PRESS;
          end
`ifdef BTN_TIMEOUT_EN
          else if (timeout_hit_c) begin
            state_d = S_TIMED_OUT;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
`endif
        end
        // Any deviation from the latched pattern is a bounce: start over.
        S_DEB_PRESS: begin
          if (sync_q != pat_q) begin
            state_d = S_READY;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_HELD: begin
          if (sync_q == '0) begin
            state_d = S_DEB_REL;
            cnt_d   = '0;
          end
        end
`ifdef BTN_TIMEOUT_EN
        S_TIMED_OUT: begin
          state_d = S_TIMED_OUT;
        end
`endif
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Next output values; busy follows the state being entered so it lines up
  // with the registered state.
  always_comb begin
    press_valid_d = 1'b0;
    multi_press_d = 1'b0;
    timeout_d     = 1'b0;
    colour_d      = colour_q;
    busy_d        = (state_d inside {S_DEB_REL, S_DEB_PRESS, S_HELD});
    if (deb_done_c) begin
      if (is_onehot(pat_q)) begin
        press_valid_d = 1'b1;
        colour_d      = btn_to_colour(pat_q);
      end else begin
        multi_press_d = 1'b1;
      end
    end
`ifdef BTN_TIMEOUT_EN
    timeout_d = timeout_hit_c;
`endif
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      press_valid_q <= 1'b0;
      multi_press_q <= 1'b0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
      colour_q      <= RED;
    end else begin
      press_valid_q <= press_valid_d;
      multi_press_q <= multi_press_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
      colour_q      <= colour_d;
    end
  end

  assign bus.press_valid  = press_valid_q;
  assign bus.multi_press  = multi_press_q;
  assign bus.busy         = busy_q;
  assign bus.timeout      = timeout_q;
  assign bus.press_colour = colour_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20).
// Expected press events (kind, colour, cycle) are queued as stimulus is driven;
// a negedge monitor queues the observed events, and each scenario compares them.
module tb_button_conditioner;

  localparam int unsigned D   = 4;
  localparam int unsigned T   = 20;
  localparam int unsigned LAT = D + 3;

  // kind: bit0 = press_valid, bit1 = multi_press
  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  colour;
    logic [31:0] cyc;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  to_q[$];
  ev_t mon_ev;

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .TIMEOUT_CYCLES  (T)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // cyc seen here equals the number of the edge that launched the value.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.press_valid || bus.multi_press) begin
        mon_ev.kind   = {bus.multi_press, bus.press_valid};
        mon_ev.colour = bus.press_colour;
        mon_ev.cyc    = 32'(cyc);
        obs_q.push_back(mon_ev);
      end
      if (bus.timeout) to_q.push_back(cyc);
    end
  end

  // Advance n edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.press_valid !== 1'b0) begin
      failures++; $display("FAIL reset_press_valid: got %b expected 0", bus.press_valid);
    end
    checks++;
    if (bus.multi_press !== 1'b0) begin
      failures++; $display("FAIL reset_multi_press: got %b expected 0", bus.multi_press);
    end
    checks++;
    if (bus.press_colour !== 2'b00) begin
      failures++; $display("FAIL reset_press_colour: got %b expected 00", bus.press_colour);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    checks++;
    if (bus.timeout !== 1'b0) begin
      failures++; $display("FAIL reset_timeout: got %b expected 0", bus.timeout);
    end
  endtask

  task automatic test_clean_press();
    int k;
    ev_t e, o;
    bus.arm = 1'b1;
    step(10);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL clean_ready_busy: got %b expected 0", bus.busy);
    end
    k = cyc;
    bus.btn_raw = 4'b0001;
    exp_q.push_back(ev_t'{2'b01, 2'b00, 32'(k + LAT)});
    step(2);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL clean_busy_before_deb: got %b expected 0", bus.busy);
    end
    step(1);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL clean_busy_in_deb: got %b expected 1", bus.busy);
    end
    step(37);
    bus.btn_raw = 4'b0000;
    step(6);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL clean_busy_release_deb: got %b expected 1", bus.busy);
    end
    step(1);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL clean_busy_after_release: got %b expected 0", bus.busy);
    end
    checks++;
    if (bus.press_colour !== 2'b00) begin
      failures++; $display("FAIL clean_colour: got %b expected 00", bus.press_colour);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL clean_event: got none expected kind=%0d colour=%0d cyc=%0d", e.kind, e.colour, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++; $display("FAIL clean_event: got kind=%0d colour=%0d cyc=%0d expected kind=%0d colour=%0d cyc=%0d", o.kind, o.colour, o.cyc, e.kind, e.colour, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL clean_extra: got %0d unexpected events (first cyc=%0d) expected 0", obs_q.size(), obs_q[0].cyc);
    end
    obs_q.delete();
  endtask

  task automatic test_bounce();
    int k;
    ev_t e, o;
    for (int i = 0; i < 10; i++) begin
      bus.btn_raw = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      step(1);
    end
    k = cyc;
    bus.btn_raw = 4'b0100;
    exp_q.push_back(ev_t'{2'b01, 2'b10, 32'(k + LAT)});
    step(20);
    bus.btn_raw = 4'b0000;
    step(10);
    checks++;
    if (bus.press_colour !== 2'b10) begin
      failures++; $display("FAIL bounce_colour: got %b expected 10", bus.press_colour);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL bounce_event: got none expected kind=%0d colour=%0d cyc=%0d", e.kind, e.colour, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++; $display("FAIL bounce_event: got kind=%0d colour=%0d cyc=%0d expected kind=%0d colour=%0d cyc=%0d", o.kind, o.colour, o.cyc, e.kind, e.colour, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL bounce_extra: got %0d unexpected events (first cyc=%0d) expected 0", obs_q.size(), obs_q[0].cyc);
    end
    obs_q.delete();
  endtask

  task automatic test_multi_press();
    int k;
    ev_t e, o;
    k = cyc;
    bus.btn_raw = 4'b0011;
    exp_q.push_back(ev_t'{2'b10, 2'b10, 32'(k + LAT)});
    step(20);
    checks++;
    if (bus.press_colour !== 2'b10) begin
      failures++; $display("FAIL multi_colour_held: got %b expected 10", bus.press_colour);
    end
    bus.btn_raw = 4'b0000;
    step(10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL multi_event: got none expected kind=%0d colour=%0d cyc=%0d", e.kind, e.colour, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++; $display("FAIL multi_event: got kind=%0d colour=%0d cyc=%0d expected kind=%0d colour=%0d cyc=%0d", o.kind, o.colour, o.cyc, e.kind, e.colour, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL multi_extra: got %0d unexpected events (first cyc=%0d) expected 0", obs_q.size(), obs_q[0].cyc);
    end
    obs_q.delete();
  endtask

  task automatic test_held_at_arm();
    int k;
    ev_t e, o;
    bus.arm = 1'b0;
    step(2);
    bus.btn_raw = 4'b1000;
    step(3);
    bus.arm = 1'b1;
    step(20);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL held_arm_busy: got %b expected 1", bus.busy);
    end
    bus.btn_raw = 4'b0000;
    step(8);
    k = cyc;
    bus.btn_raw = 4'b1000;
    exp_q.push_back(ev_t'{2'b01, 2'b11, 32'(k + LAT)});
    step(20);
    bus.btn_raw = 4'b0000;
    step(10);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL held_arm_event: got none expected kind=%0d colour=%0d cyc=%0d", e.kind, e.colour, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++; $display("FAIL held_arm_event: got kind=%0d colour=%0d cyc=%0d expected kind=%0d colour=%0d cyc=%0d", o.kind, o.colour, o.cyc, e.kind, e.colour, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL held_arm_extra: got %0d unexpected events (first cyc=%0d) expected 0", obs_q.size(), obs_q[0].cyc);
    end
    obs_q.delete();
  endtask

  task automatic test_arm_drop();
    bus.btn_raw = 4'b0010;
    step(5);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL arm_drop_busy_deb: got %b expected 1", bus.busy);
    end
    bus.arm = 1'b0;
    step(1);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL arm_drop_busy_next: got %b expected 0", bus.busy);
    end
    step(10);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL arm_drop_idle_hold: got %b expected 0", bus.busy);
    end
    bus.btn_raw = 4'b0000;
    bus.arm = 1'b1;
    step(10);
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL arm_drop_extra: got %0d unexpected events (first cyc=%0d) expected 0", obs_q.size(), obs_q[0].cyc);
    end
    obs_q.delete();
  endtask

  task automatic test_arm_priority();
    bus.btn_raw = 4'b0010;
    step(6);
    bus.arm = 1'b0;
    step(1);
    checks++;
    if (bus.press_valid !== 1'b0) begin
      failures++; $display("FAIL arm_priority_pulse: got %b expected 0", bus.press_valid);
    end
    step(3);
    bus.btn_raw = 4'b0000;
    bus.arm = 1'b1;
    step(10);
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL arm_priority_extra: got %0d unexpected events (first cyc=%0d) expected 0", obs_q.size(), obs_q[0].cyc);
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    bus.btn_raw = 4'b0001;
    step(5);
    reset = 1'b1;
    step(1);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_mid_busy: got %b expected 0", bus.busy);
    end
    checks++;
    if (bus.press_colour !== 2'b00) begin
      failures++; $display("FAIL reset_mid_colour: got %b expected 00", bus.press_colour);
    end
    step(1);
    reset = 1'b0;
    step(5);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL reset_mid_rearm_busy: got %b expected 1", bus.busy);
    end
    bus.btn_raw = 4'b0000;
    step(10);
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL reset_mid_extra: got %0d unexpected events (first cyc=%0d) expected 0", obs_q.size(), obs_q[0].cyc);
    end
    obs_q.delete();
  endtask

  task automatic test_timeout();
    int a;
    checks++;
    if (to_q.size() != 0) begin
      failures++; $display("FAIL timeout_early: got %0d pulses (first cyc=%0d) expected 0", to_q.size(), to_q[0]);
    end
    to_q.delete();
    bus.arm = 1'b0;
    step(2);
    a = cyc;
    bus.arm = 1'b1;
    step(80);
`ifdef BTN_TIMEOUT_EN
    checks++;
    if (to_q.size() != 1) begin
      failures++; $display("FAIL timeout_count: got %0d pulses expected 1", to_q.size());
    end else begin
      checks++;
      if (to_q[0] != a + int'(D) + 1 + int'(T)) begin
        failures++; $display("FAIL timeout_cycle: got %0d expected %0d", to_q[0], a + int'(D) + 1 + int'(T));
      end
    end
`else
    checks++;
    if (to_q.size() != 0) begin
      failures++; $display("FAIL timeout_disabled: got %0d pulses (first cyc=%0d) expected 0", to_q.size(), to_q[0]);
    end
`endif
    checks++;
    if (bus.timeout !== 1'b0) begin
      failures++; $display("FAIL timeout_level: got %b expected 0", bus.timeout);
    end
  endtask

  initial begin
    bus.arm     = 1'b0;
    bus.btn_raw = 4'b0000;
    reset       = 1'b1;
    step(3);
    test_reset();
    reset = 1'b0;
    step(1);
    test_clean_press();
    test_bounce();
    test_multi_press();
    test_held_at_arm();
    test_arm_drop();
    test_arm_priority();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
